rf68000_nic_server: RTL
=======================

Name: rf68000_nic_server

Overview:
- Ring endpoint for the global server node (default ring id 62), the responder end of the request/response packet rings.
- Removes request packets addressed to its id from the request ring and queues them in order.
- Replays each queued request as a bus-master cycle on the shared memory/IO bus.
- Returns read results as response packets on the response ring. Writes are posted and produce no response.

Parameters:
ID, 6'd62, ring node id served; must not be 0 or 63
DEPTH, 4, request FIFO entries; power of 2, minimum 2
TMO_BITS, 8, bus timeout fires when the master-cycle counter reaches 2**TMO_BITS cycles (256)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
packet_i  in  packet_t  request ring in
packet_o  out  packet_t  request ring out
rpacket_i  in  packet_t  response ring in
rpacket_o  out  packet_t  response ring out
m_cyc_o, m_stb_o, m_we_o  out  1  bus-master cycle, strobe, write
m_ack_i, m_err_i, m_vpa_i  in  1  bus terminations
m_sel_o  out  4  byte selects
m_asid_o  out  8  address-space id
m_adr_o, m_dat_o  out  32  address, write data
m_dat_i  in  32  read data
m_mmus_o, m_ios_o, m_iops_o  out  1  space qualifiers copied from the request packet
busy_o  out  1  FIFO non-empty or bus cycle active or response pending
werr_o  out  1  one-cycle pulse on a write terminated by err or timeout

Behaviour:
- Reset: all outputs 0, packet_o/rpacket_o all-zero, FIFO empty, response buffer invalid, state IDLE, timeout counter 0. A reset mid-cycle drops m_cyc_o next edge and discards queued work.
- Ring pass-through: packet_o<=packet_i and rpacket_o<=rpacket_i every cycle (1-cycle latency), unless overridden below.
- Capture:
  - If packet_i.did==ID, typ is PT_READ, PT_AREAD or PT_WRITE, and the FIFO is not full: push packet_i and set packet_o.did<=0.
  - If the FIFO is full: the packet passes through unchanged and is served when it comes back around the ring.
  - did==ID with any other typ: removed (did<=0) and dropped.
  - did==63 broadcasts pass through untouched.
- FIFO: in-order. Push and pop in the same cycle are allowed; count is unchanged.
- Master FSM:
  - IDLE -> BUS when the FIFO is non-empty, the response buffer is invalid and !m_ack_i. Drive m_cyc_o/m_stb_o=1 and load we/sel/asid/adr/dat/mmus/ios/iops from the FIFO head.
  - BUS: timeout counter increments each cycle while m_cyc_o=1. Priority is ack > err > vpa > timeout. On termination: clear cyc/stb/we/sel/qualifiers, pop the head, return to IDLE, reset the counter.
  - Read termination loads the response buffer:
    - typ = PT_AACK for an AREAD ack, PT_ACK for a READ ack, PT_VPA for vpa, PT_ERR for err or timeout.
    - did=head.sid, sid=ID, age=0, ack=1, asid/mmus/ios/iops/adr copied from the head.
    - dat = m_dat_i on ack/vpa, 0 on err/timeout.
  - Write termination: no response. werr_o pulses on err or timeout.
- Response transmit: when the response buffer is valid and rpacket_i.did==0, rpacket_o<=buffer and the buffer is invalidated that cycle. An occupied slot holds the buffer, which also stalls the next bus cycle.
- Minimum request-to-cyc latency: capture edge, then m_cyc_o asserted at the following edge.

Optional Feature:
NIC_SERVER_RETRY_EN
- Defined: a read request arriving with the FIFO full is removed (did<=0) and answered with PT_RETRY (dat=0, adr copied). This uses a 1-entry retry buffer with priority over the normal response buffer for empty slots. If the retry buffer is also occupied, the packet passes through. Writes always pass through when full.
- Undefined: full-FIFO requests always pass through.

Decomposition:
- nic_pkg (existing): packet_t, PT_* codes, TRUE/FALSE.
- Add to nic_pkg: server FSM enum (SV_IDLE, SV_BUS).
- One sub-module: rf68000_nic_req_fifo, a synchronous packet_t FIFO with push/pop/full/empty/count.

Test Plan:
1. PT_READ did=62 sid=5 adr=32'h40001000 -> packet_o.did=0 next cycle; m_adr_o=40001000 with m_cyc_o=1 two edges after injection. Then m_ack_i with m_dat_i=DEADBEEF -> rpacket_o typ=PT_ACK, did=5, sid=62, dat=DEADBEEF.
2. PT_AREAD -> PT_AACK. PT_WRITE dat=12345678 -> m_we_o=1, m_dat_o=12345678, no response packet, werr_o stays 0.
3. Slave stalled, 5 back-to-back READs -> 4 captured; 5th appears on packet_o with did=62. After acks it is captured on re-entry, and exactly 5 responses are sent in order.
4. No termination -> m_cyc_o drops at cycle 256 and a PT_ERR response with dat=0 is sent. The same on a write -> one werr_o pulse and no response.
5. rpacket_i.did=7 for 10 cycles after a read ack -> response held and the next queued request not started; response sent on the first did==0 cycle, then the next bus cycle starts.
6. rst_i asserted during BUS -> m_cyc_o=0 next edge, FIFO empty, busy_o=0; a RETRY_EN build returns PT_RETRY for a full-FIFO read.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared ring packet format, packet type codes and server FSM states.
// Included by every node on the request/response rings.
package nic_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [3:0] {
        PT_NULL  = 4'd0,
        PT_READ  = 4'd1,
        PT_WRITE = 4'd2,
        PT_AREAD = 4'd3,
        PT_ACK   = 4'd4,
        PT_AACK  = 4'd5,
        PT_ERR   = 4'd6,
        PT_VPA   = 4'd7,
        PT_RETRY = 4'd8
    } pkt_type_t;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        pkt_type_t   typ;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

    typedef enum logic {
        SV_IDLE = 1'b0,
        SV_BUS  = 1'b1
    } sv_state_t;

    // Response addressed back to the requester, carrying its address and qualifiers.
    function automatic packet_t mk_rsp(input packet_t req, input logic [5:0] id,
                                       input pkt_type_t typ, input logic [31:0] dat);
        packet_t r;
        r      = '0;
        r.did  = req.sid;
        r.sid  = id;
        r.ack  = TRUE;
        r.typ  = typ;
        r.asid = req.asid;
        r.mmus = req.mmus;
        r.ios  = req.ios;
        r.iops = req.iops;
        r.adr  = req.adr;
        r.dat  = dat;
        return r;
    endfunction

endpackage

// File: rtl/rf68000_nic_req_fifo.sv
// In-order packet FIFO holding captured requests; head visible combinationally.
// Latency: a pushed entry is visible at dout one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module rf68000_nic_req_fifo
    import nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  packet_t                din,
    output packet_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    packet_t         mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            push_vld;
    logic            pop_vld;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_vld = push && !full;
    assign pop_vld  = pop && !empty;
    assign dout     = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wptr] <= din;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_vld) wptr <= wptr + 1'b1;
            if (pop_vld)  rptr <= rptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf68000_nic_server.sv
// Server ring endpoint: captures requests for ID, replays them on the bus, returns read responses.
// Latency: ring pass-through 1 cycle; capture to m_cyc_o 1 further cycle. Optional NIC_SERVER_RETRY_EN.
// Backpressure: full FIFO passes requests on round the ring; occupied response slot holds the response and stalls the bus.
module rf68000_nic_server
    import nic_pkg::*;
#(
    parameter logic [5:0] ID       = 6'd62,
    parameter int         DEPTH    = 4,
    parameter int         TMO_BITS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_vpa_i,
    output logic [3:0]  m_sel_o,
    output logic [7:0]  m_asid_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_mmus_o,
    output logic        m_ios_o,
    output logic        m_iops_o,
    output logic        busy_o,
    output logic        werr_o
);
    packet_t                head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   fifo_push;
    logic                   fifo_pop;

    sv_state_t              state;
    logic [TMO_BITS-1:0]    tmo_cnt;
    packet_t                rsp_buf;
    logic                   rsp_vld;
    packet_t                retry_buf;
    logic                   retry_vld;
    logic                   retry_load;

    logic                   id_hit;
    logic                   is_req;
    logic                   slot_free;
    logic                   bus_done;
    pkt_type_t              rsp_typ;
    logic [31:0]            rsp_dat;
    logic                   unused_head;

    assign id_hit    = (packet_i.did == ID);
    assign is_req    = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD) ||
                       (packet_i.typ == PT_WRITE);
    assign fifo_push = id_hit && is_req && !fifo_full;
    assign slot_free = (rpacket_i.did == '0);
    assign bus_done  = (state == SV_BUS) && (m_ack_i || m_err_i || m_vpa_i || (&tmo_cnt));
    assign fifo_pop  = bus_done;
    assign busy_o    = (fifo_cnt != '0) || m_cyc_o || rsp_vld || retry_vld;
    assign unused_head = ^{head.did, head.age, head.ack};

    always_comb begin
        rsp_typ = PT_ERR;
        rsp_dat = '0;
        if (m_ack_i) begin
            rsp_typ = (head.typ == PT_AREAD) ? PT_AACK : PT_ACK;
            rsp_dat = m_dat_i;
        end else if (m_err_i) begin
            rsp_typ = PT_ERR;
        end else if (m_vpa_i) begin
            rsp_typ = PT_VPA;
            rsp_dat = m_dat_i;
        end
    end

    rf68000_nic_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (packet_i),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

`ifdef NIC_SERVER_RETRY_EN
    // Reads bounced by a full FIFO get an immediate RETRY instead of another lap.
    assign retry_load = id_hit && fifo_full && !retry_vld &&
                        ((packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_vld <= FALSE;
            retry_buf <= '0;
        end else begin
            if (retry_vld && slot_free) retry_vld <= FALSE;
            if (retry_load) begin
                retry_vld <= TRUE;
                retry_buf <= mk_rsp(packet_i, ID, PT_RETRY, 32'd0);
            end
        end
    end
`else
    assign retry_load = FALSE;
    assign retry_vld  = FALSE;
    assign retry_buf  = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            packet_o  <= '0;
            rpacket_o <= '0;
            rsp_buf   <= '0;
            rsp_vld   <= FALSE;
        end else begin
            packet_o <= packet_i;
            if (id_hit && (fifo_push || retry_load || !is_req)) packet_o.did <= '0;

            rpacket_o <= rpacket_i;
            if (slot_free) begin
                if (retry_vld) begin
                    rpacket_o <= retry_buf;
                end else if (rsp_vld) begin
                    rpacket_o <= rsp_buf;
                    rsp_vld   <= FALSE;
                end
            end

            if (bus_done && (head.typ != PT_WRITE)) begin
                rsp_vld <= TRUE;
                rsp_buf <= mk_rsp(head, ID, rsp_typ, rsp_dat);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= SV_IDLE;
            tmo_cnt  <= '0;
            m_cyc_o  <= FALSE;
            m_stb_o  <= FALSE;
            m_we_o   <= FALSE;
            m_sel_o  <= '0;
            m_asid_o <= '0;
            m_adr_o  <= '0;
            m_dat_o  <= '0;
            m_mmus_o <= FALSE;
            m_ios_o  <= FALSE;
            m_iops_o <= FALSE;
            werr_o   <= FALSE;
        end else begin
            werr_o <= FALSE;
            case (state)
                SV_IDLE: begin
                    if (!fifo_empty && !rsp_vld && !m_ack_i) begin
                        state    <= SV_BUS;
                        m_cyc_o  <= TRUE;
                        m_stb_o  <= TRUE;
                        m_we_o   <= (head.typ == PT_WRITE);
                        m_sel_o  <= head.sel;
                        m_asid_o <= head.asid;
                        m_adr_o  <= head.adr;
                        m_dat_o  <= head.dat;
                        m_mmus_o <= head.mmus;
                        m_ios_o  <= head.ios;
                        m_iops_o <= head.iops;
                    end
                end
                SV_BUS: begin
                    if (bus_done) begin
                        state    <= SV_IDLE;
                        tmo_cnt  <= '0;
                        m_cyc_o  <= FALSE;
                        m_stb_o  <= FALSE;
                        m_we_o   <= FALSE;
                        m_sel_o  <= '0;
                        m_mmus_o <= FALSE;
                        m_ios_o  <= FALSE;
                        m_iops_o <= FALSE;
                        // Posted writes only report failure: err or timeout, never ack/vpa.
                        werr_o   <= m_we_o && !m_ack_i && !m_vpa_i;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= SV_IDLE;
            endcase
        end
    end

endmodule
